// File: rtl/smem_req_arbiter.sv
// Shared-memory request arbiter.
// Grants one requester's lane batch at a time in round-robin order and holds
// the grant until every valid lane of that batch has been accepted. The
// requester index is appended to the tag in the LSBs, so a response can be
// routed straight back to its requester without any storage.
module smem_req_arbiter #(
  parameter int NUM_INPUTS    = 2,
  parameter int NUM_REQS      = 4,
  parameter int WORD_SIZE     = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int TAG_IN_WIDTH  = 10,
  parameter int SEL_BITS      = $clog2(NUM_INPUTS),
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]               in_req_valid,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]               in_req_rw,
  input  logic [NUM_INPUTS*NUM_REQS*ADDR_WIDTH-1:0]    in_req_addr,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE-1:0]     in_req_byteen,
  input  logic [NUM_INPUTS*NUM_REQS*8*WORD_SIZE-1:0]   in_req_data,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]           in_req_tag,
  output logic [NUM_INPUTS*NUM_REQS-1:0]               in_req_ready,
  output logic [NUM_REQS-1:0]                          out_req_valid,
  output logic [NUM_REQS-1:0]                          out_req_rw,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]               out_req_addr,
  output logic [NUM_REQS*WORD_SIZE-1:0]                out_req_byteen,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]              out_req_data,
  output logic [NUM_REQS*TAG_OUT_WIDTH-1:0]            out_req_tag,
  input  logic [NUM_REQS-1:0]                          out_req_ready,
  input  logic                                         out_rsp_valid,
  input  logic [NUM_REQS-1:0]                          out_rsp_tmask,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]              out_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]                     out_rsp_tag,
  output logic                                         out_rsp_ready,
  output logic [NUM_INPUTS-1:0]                        in_rsp_valid,
  output logic [NUM_INPUTS*NUM_REQS-1:0]               in_rsp_tmask,
  output logic [NUM_INPUTS*NUM_REQS*8*WORD_SIZE-1:0]   in_rsp_data,
  output logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]           in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]                        in_rsp_ready,
  output logic [PERF_CTR_BITS-1:0]                     perf_stalls
);

  localparam int DATA_W = 8 * WORD_SIZE;

  if (NUM_INPUTS < 2) begin : g_bad_cfg
    $error("smem_req_arbiter: NUM_INPUTS must be at least 2");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [SEL_BITS-1:0]       rr_ptr, rr_ptr_d;
  logic [SEL_BITS-1:0]       lock_idx, lock_idx_d;
  logic [NUM_REQS-1:0]       pend_mask, pend_mask_d;
  logic [PERF_CTR_BITS-1:0]  perf_cnt;

  logic [NUM_INPUTS-1:0]     any_valid;
  logic [2*NUM_INPUTS-1:0]   any_valid_dbl;
  logic [NUM_INPUTS-1:0]     rotated;
  logic                      grant_found;
  logic [SEL_BITS:0]         grant_off;
  logic [SEL_BITS:0]         grant_sum;
  logic [SEL_BITS-1:0]       grant;
  logic [SEL_BITS-1:0]       owner;
  logic                      active;
  logic [NUM_REQS-1:0]       owner_valid;
  logic [NUM_REQS-1:0]       drive_mask;
  logic [TAG_IN_WIDTH-1:0]   owner_tag;
  logic [SEL_BITS:0]         stall_cnt;
  logic [SEL_BITS-1:0]       rsp_sel;

  // Index after idx, wrapping at NUM_INPUTS (not at a power of two).
  function automatic logic [SEL_BITS-1:0] wrap_inc(input logic [SEL_BITS-1:0] idx);
    if (idx == SEL_BITS'(NUM_INPUTS - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Per-requester "has at least one valid lane" summary.
  always_comb begin
    any_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      any_valid[i] = |in_req_valid[i*NUM_REQS +: NUM_REQS];
    end
    any_valid_dbl = {any_valid, any_valid};
    rotated       = NUM_INPUTS'(any_valid_dbl >> rr_ptr);
  end

  // Round-robin pick: first active requester at or after rr_ptr, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        grant_found = 1'b1;
        grant_off   = (SEL_BITS+1)'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr} + grant_off;
    if (grant_sum >= (SEL_BITS+1)'(NUM_INPUTS)) begin
      grant_sum = grant_sum - (SEL_BITS+1)'(NUM_INPUTS);
    end
    grant = grant_sum[SEL_BITS-1:0];
  end

  // Owner of the port this cycle and the lane mask actually presented downstream.
  always_comb begin
    owner       = (state_q == LOCKED) ? lock_idx : grant;
    active      = (state_q == LOCKED) || grant_found;
    owner_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (owner == SEL_BITS'(i)) begin
        owner_valid = in_req_valid[i*NUM_REQS +: NUM_REQS];
      end
    end
    if (reset || !active) begin
      drive_mask = '0;
    end else if (state_q == LOCKED) begin
      drive_mask = pend_mask;
    end else begin
      drive_mask = owner_valid;
    end
  end

  // Request mux toward shared memory and ready fan-back to the owner only.
  always_comb begin
    out_req_valid  = drive_mask;
    out_req_rw     = '0;
    out_req_addr   = '0;
    out_req_byteen = '0;
    out_req_data   = '0;
    owner_tag      = '0;
    in_req_ready   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (owner == SEL_BITS'(i)) begin
        out_req_rw     = in_req_rw[i*NUM_REQS +: NUM_REQS];
        out_req_addr   = in_req_addr[i*NUM_REQS*ADDR_WIDTH +: NUM_REQS*ADDR_WIDTH];
        out_req_byteen = in_req_byteen[i*NUM_REQS*WORD_SIZE +: NUM_REQS*WORD_SIZE];
        out_req_data   = in_req_data[i*NUM_REQS*DATA_W +: NUM_REQS*DATA_W];
        owner_tag      = in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
        in_req_ready[i*NUM_REQS +: NUM_REQS] = drive_mask & out_req_ready;
      end
    end
    out_req_tag = {NUM_REQS{{owner_tag, owner}}};
  end

  // Number of requesters waiting with valid lanes while someone else owns the port.
  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (any_valid[i] && !(active && (owner == SEL_BITS'(i)))) begin
        stall_cnt = stall_cnt + 1'b1;
      end
    end
  end

  // Next-state: release on full acceptance, otherwise lock the remaining lanes.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr;
    lock_idx_d  = lock_idx;
    pend_mask_d = pend_mask;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          if ((owner_valid & ~out_req_ready) == '0) begin
            rr_ptr_d = wrap_inc(grant);
          end else begin
            state_d     = LOCKED;
            lock_idx_d  = grant;
            pend_mask_d = owner_valid & ~out_req_ready;
          end
        end
      end
      LOCKED: begin
        pend_mask_d = pend_mask & ~out_req_ready;
        if (pend_mask_d == '0) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(lock_idx);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any batch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      lock_idx  <= '0;
      pend_mask <= '0;
      perf_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      lock_idx  <= lock_idx_d;
      pend_mask <= pend_mask_d;
      perf_cnt  <= perf_cnt + PERF_CTR_BITS'(stall_cnt);
    end
  end

  assign perf_stalls = perf_cnt;

  // Response demux: the tag LSBs select the requester; payload is broadcast.
  always_comb begin
    rsp_sel       = out_rsp_tag[SEL_BITS-1:0];
    in_rsp_valid  = '0;
    out_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_sel == SEL_BITS'(i)) begin
        in_rsp_valid[i] = out_rsp_valid;
        out_rsp_ready   = in_rsp_ready[i];
      end
    end
    in_rsp_tmask = {NUM_INPUTS{out_rsp_tmask}};
    in_rsp_data  = {NUM_INPUTS{out_rsp_data}};
    in_rsp_tag   = {NUM_INPUTS{out_rsp_tag[TAG_OUT_WIDTH-1:SEL_BITS]}};
  end

  // A locked requester must keep every pending lane valid until it is taken.
  a_hold_pending: assert property (@(posedge clk) disable iff (reset)
    (state_q == LOCKED) |-> ((owner_valid & pend_mask) == pend_mask));

  // Responses must carry a requester index that exists.
  a_rsp_sel_range: assert property (@(posedge clk) disable iff (reset)
    out_rsp_valid |-> ({1'b0, rsp_sel} < (SEL_BITS+1)'(NUM_INPUTS)));

endmodule
